imm_packer: RTL and testbench

Immediate packer and instruction-stream emitter: the inverse of the decode-side immediate extender. It accepts a full 32-bit immediate, an immediate-format code, and a base instruction word. It places the immediate bits into the format's instruction-field positions, range-checks the value, and emits the packed word with a running word address. It sits between the self-test/program-generator logic and instruction-memory write port, so that generated programs decode back to the intended immediates.

---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_field_pack.sv | 60 ++++++
 rtl/imm_packer.sv | 96 +++++++++
 tb/tb_imm_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate-format encoding shared by the immediate packer and the decode-side extender.
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_J  = 3'd3,
    IMM_U  = 3'd4,
    IMM_LI = 3'd5
  } imm_src_t;

endpackage

// File: rtl/imm_field_pack.sv
// Places an immediate into its format's instruction fields and flags values the format cannot carry.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [2:0]         i_src,
  input  logic [INSTR_W-1:0] i_imm,
  input  logic [INSTR_W-1:0] i_base,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_err
);

  // Each check asks whether the discarded high bits are pure sign extension.
  logic w_i_ok;
  logic w_b_ok;
  logic w_j_ok;

  assign w_i_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_b_ok = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
  assign w_j_ok = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];

  always_comb begin
    o_instr = i_base;
    o_err   = 1'b0;
    case (i_src)
      IMM_I: begin
        o_instr[31:20] = i_imm[11:0];
        o_err          = ~w_i_ok;
      end
      IMM_S: begin
        o_instr[31:25] = i_imm[11:5];
        o_instr[11:7]  = i_imm[4:0];
        o_err          = ~w_i_ok;
      end
      IMM_B: begin
        o_instr[31]    = i_imm[12];
        o_instr[7]     = i_imm[11];
        o_instr[30:25] = i_imm[10:5];
        o_instr[11:8]  = i_imm[4:1];
        o_err          = ~w_b_ok;
      end
      IMM_J: begin
        o_instr[31]    = i_imm[20];
        o_instr[19:12] = i_imm[19:12];
        o_instr[20]    = i_imm[11];
        o_instr[30:21] = i_imm[10:1];
        o_err          = ~w_j_ok;
      end
      IMM_U: begin
        o_instr[31:12] = i_imm[31:12];
        o_err          = |i_imm[11:0];
      end
      IMM_LI: begin
        o_instr[24:20] = i_imm[4:0];
        o_err          = |i_imm[31:5];
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Packs immediates into instruction words behind one output register stage,
// tagging each word with a running byte address and tracking range errors.
module imm_packer
  import imm_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                 ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_src,
  input  logic [INSTR_W-1:0]   in_imm,
  input  logic [INSTR_W-1:0]   in_base,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [INSTR_W-1:0]   out_addr,
  output logic                 out_err,
  output logic                 err_range,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [INSTR_W-1:0]   w_instr;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_xfer;
  logic [INSTR_W-1:0]   w_load_addr;

  logic                 r_vld;
  logic [INSTR_W-1:0]   r_instr;
  logic [INSTR_W-1:0]   r_addr;
  logic                 r_err;
  logic [INSTR_W-1:0]   r_next_addr;
  logic                 r_err_range;
  logic [ERR_CNT_W-1:0] r_err_count;

  imm_field_pack u_pack (
    .i_src   (in_src),
    .i_imm   (in_imm),
    .i_base  (in_base),
    .o_instr (w_instr),
    .o_err   (w_err)
  );

  assign in_ready    = rst_n && (!r_vld || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_xfer      = r_vld && out_ready;
  // Every loaded word is eventually transferred, so stepping the address at
  // load time yields previous+4 per transfer while leaving a held word's tag alone.
  assign w_load_addr = clear ? BASE_ADDR : r_next_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld       <= 1'b0;
      r_instr     <= '0;
      r_addr      <= BASE_ADDR;
      r_err       <= 1'b0;
      r_next_addr <= BASE_ADDR;
      r_err_range <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_vld       <= 1'b1;
        r_instr     <= w_instr;
        r_err       <= w_err;
        r_addr      <= w_load_addr;
        r_next_addr <= w_load_addr + 32'd4;
      end else begin
        if (w_xfer)
          r_vld <= 1'b0;
        if (clear)
          r_next_addr <= BASE_ADDR;
      end

      if (clear) begin
        r_err_range <= 1'b0;
        r_err_count <= '0;
      end else if (w_xfer && r_err) begin
        r_err_range <= 1'b1;
        if (r_err_count != {ERR_CNT_W{1'b1}})
          r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign out_valid = r_vld;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign out_err   = r_err;
  assign err_range = r_err_range;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_packer.sv
// Directed and round-trip bench for imm_packer; base address chosen near the top so the wrap shows up early.
module tb_imm_packer;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_src;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_range;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;

  imm_packer #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_src    (in_src),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_range (err_range),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Decode-side extender, written from the field table.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0: extend = {{20{i[31]}}, i[31:20]};
      3'd1: extend = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: extend = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: extend = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: extend = {i[31:12], 12'h000};
      default: extend = {27'd0, i[24:20]};
    endcase
  endfunction

  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
    int n;
    in_src   = src;
    in_imm   = imm;
    in_base  = base;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_src = 3'd0; in_imm = '0; in_base = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got=%h required 0", out_instr); end
    checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rst_out_addr got=%h required %h", out_addr, BASE); end
    checks++; if (out_err !== 1'b0 || err_range !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_err got=%b/%b/%0d required 0/0/0", out_err, err_range, err_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b required 1", in_ready); end
    exp_addr = BASE;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_0013 || out_err !== 1'b0) begin
      errors++; $display("FAIL i_neg1 got=%b/%h/%b required 1/fff00013/0", out_valid, out_instr, out_err); end
    checks++; if (out_addr !== BASE) begin errors++; $display("FAIL i_neg1_addr got=%h required %h", out_addr, BASE); end
    send(3'd2, 32'h0000_0800, 32'h0000_0063);
    checks++; if (out_instr !== 32'h0000_00E3 || out_err !== 1'b0) begin
      errors++; $display("FAIL b_800 got=%h/%b required 000000e3/0", out_instr, out_err); end
    checks++; if (out_addr !== BASE + 32'd4) begin errors++; $display("FAIL b_800_addr got=%h required %h", out_addr, BASE + 32'd4); end
    send(3'd0, 32'h0000_0800, 32'h0000_0013);
    checks++; if (out_instr !== 32'h8000_0013 || out_err !== 1'b1) begin
      errors++; $display("FAIL i_range got=%h/%b required 80000013/1", out_instr, out_err); end
    checks++; if (out_addr !== 32'h0000_0000) begin errors++; $display("FAIL addr_wrap got=%h required 00000000", out_addr); end
    checks++; if (err_range !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL err_before_xfer got=%b/%0d required 0/0", err_range, err_count); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || err_range !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL err_after_xfer got=%b/%b/%0d required 0/1/1", out_valid, err_range, err_count); end
    exp_addr = 32'h0000_0004;
  endtask

  task automatic test_errors();
    send(3'd3, 32'h0000_0003, 32'h0000_006F);
    checks++; if (out_instr !== 32'h0020_006F || out_err !== 1'b1 || out_addr !== exp_addr) begin
      errors++; $display("FAIL j_odd got=%h/%b/%h required 0020006f/1/%h", out_instr, out_err, out_addr, exp_addr); end
    send(3'd7, 32'h0000_0000, 32'hDEAD_BEEF);
    checks++; if (out_instr !== 32'hDEAD_BEEF || out_err !== 1'b1 || out_addr !== exp_addr + 32'd4) begin
      errors++; $display("FAIL src7 got=%h/%b/%h required deadbeef/1/%h", out_instr, out_err, out_addr, exp_addr + 32'd4); end
    @(posedge clk); #1;
    checks++; if (err_count !== 8'd3 || err_range !== 1'b1) begin
      errors++; $display("FAIL err_count3 got=%0d/%b required 3/1", err_count, err_range); end
    exp_addr = exp_addr + 32'd8;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(3'd4, 32'h1234_5000, 32'h0000_0037);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h1234_5037 || in_ready !== 1'b0 || out_addr !== exp_addr || out_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%h/%b required 1/12345037/0/%h/0",
                 c, out_valid, out_instr, in_ready, out_addr, out_err, exp_addr);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b required 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || err_count !== 8'd3) begin
      errors++; $display("FAIL stall_single got=%b/%0d required 0/3", out_valid, err_count); end
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    send(3'd6, 32'h0000_0000, 32'h0000_0013);
    checks++; if (out_err !== 1'b1 || out_addr !== exp_addr || out_instr !== 32'h0000_0013) begin
      errors++; $display("FAIL src6 got=%b/%h/%h required 1/%h/00000013", out_err, out_addr, out_instr, exp_addr); end
    clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || err_count !== 8'd0 || err_range !== 1'b0) begin
      errors++; $display("FAIL clear_xfer got=%b/%0d/%b required 0/0/0", out_valid, err_count, err_range); end
    send(3'd5, 32'h0000_001F, 32'h0000_0013);
    checks++; if (out_instr !== 32'h01F0_0013 || out_err !== 1'b0 || out_addr !== BASE) begin
      errors++; $display("FAIL li_after_clear got=%h/%b/%h required 01f00013/0/%h", out_instr, out_err, out_addr, BASE); end
    send(3'd1, 32'hFFFF_FFF5, 32'h0000_0023);
    checks++; if (out_instr !== 32'hFE00_0AA3 || out_err !== 1'b0 || out_addr !== BASE + 32'd4) begin
      errors++; $display("FAIL s_neg11 got=%h/%b/%h required fe000aa3/0/%h", out_instr, out_err, out_addr, BASE + 32'd4); end
    @(posedge clk); #1;
    exp_addr = BASE + 32'd8;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 260; k++) begin
      send(3'd7, 32'(k), 32'h0000_0013);
      exp_addr = exp_addr + 32'd4;
    end
    checks++; if (out_addr !== exp_addr - 32'd4) begin
      errors++; $display("FAIL sat_last_addr got=%h required %h", out_addr, exp_addr - 32'd4); end
    @(posedge clk); #1;
    checks++; if (err_count !== 8'd255 || err_range !== 1'b1) begin
      errors++; $display("FAIL err_saturate got=%0d/%b required 255/1", err_count, err_range); end
  endtask

  task automatic test_round_trip();
    logic [31:0] r;
    logic [31:0] imm;
    logic [31:0] base;
    logic [2:0]  src;
    for (int k = 0; k < 300; k++) begin
      r    = $urandom;
      base = $urandom;
      src  = 3'($urandom_range(0, 5));
      case (src)
        3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
        3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
        3'd4:       imm = {r[31:12], 12'h000};
        default:    imm = {27'd0, r[4:0]};
      endcase
      send(src, imm, base);
      checks++;
      if (out_err !== 1'b0 || extend(out_instr, src) !== imm || out_instr[6:0] !== base[6:0] || out_addr !== exp_addr) begin
        errors++;
        $display("FAIL round_trip src=%0d imm=%h got err=%b ext=%h op=%h addr=%h required 0/%h/%h/%h",
                 src, imm, out_err, extend(out_instr, src), out_instr[6:0], out_addr, imm, base[6:0], exp_addr);
      end
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0005, 32'h0000_0013);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready got=%b required 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_addr !== BASE || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_mid_stall got=%b/%h/%0d required 0/%h/0", out_valid, out_addr, err_count, BASE); end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_errors();
    test_stall();
    test_clear();
    test_saturate();
    test_round_trip();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
